// File: rtl/rtype_exec_unit.sv
// R-type reservation station, single-cycle ALU and CDB result driver.
// Optional same-cycle CDB capture at issue: define RTYPE_CDB_BYPASS_EN.
module rtype_exec_unit #(
    parameter int RS_DEPTH = 2,
    parameter int TAG_W    = 7,
    parameter int XLEN     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [5:0]       iss_funct,
    input  logic [TAG_W-1:0] iss_dest_tag,
    input  logic             iss_s1_rdy,
    input  logic [TAG_W-1:0] iss_s1_tag,
    input  logic [XLEN-1:0]  iss_s1_val,
    input  logic             iss_s2_rdy,
    input  logic [TAG_W-1:0] iss_s2_tag,
    input  logic [XLEN-1:0]  iss_s2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_val,
    output logic             res_req,
    input  logic             res_grant,
    output logic [TAG_W-1:0] res_tag,
    output logic [XLEN-1:0]  res_val,
    output logic             rs_full
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    localparam logic [5:0] F_ADD  = 6'b011011;
    localparam logic [5:0] F_SUB  = 6'b011100;
    localparam logic [5:0] F_SLL  = 6'b011101;
    localparam logic [5:0] F_SLT  = 6'b011110;
    localparam logic [5:0] F_SLTU = 6'b011111;
    localparam logic [5:0] F_XOR  = 6'b100000;
    localparam logic [5:0] F_SRL  = 6'b100001;
    localparam logic [5:0] F_SRA  = 6'b100010;
    localparam logic [5:0] F_OR   = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;

    typedef enum logic {
        S_IDLE,
        S_PEND
    } state_t;

    logic [RS_DEPTH-1:0] r_busy;
    logic [5:0]          r_funct  [RS_DEPTH];
    logic [TAG_W-1:0]    r_dtag   [RS_DEPTH];
    logic [RS_DEPTH-1:0] r_s1_rdy;
    logic [TAG_W-1:0]    r_s1_tag [RS_DEPTH];
    logic [XLEN-1:0]     r_s1_val [RS_DEPTH];
    logic [RS_DEPTH-1:0] r_s2_rdy;
    logic [TAG_W-1:0]    r_s2_tag [RS_DEPTH];
    logic [XLEN-1:0]     r_s2_val [RS_DEPTH];

    state_t              r_state;
    logic                r_res_req;
    logic [TAG_W-1:0]    r_res_tag;
    logic [XLEN-1:0]     r_res_val;

    logic                w_has_free;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_has_rdy;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_do_issue;
    logic                w_dispatch;
    logic                w_s1_rdy_in;
    logic [XLEN-1:0]     w_s1_val_in;
    logic                w_s2_rdy_in;
    logic [XLEN-1:0]     w_s2_val_in;
    logic [XLEN-1:0]     w_a;
    logic [XLEN-1:0]     w_b;
    logic [4:0]          w_sh;
    logic [XLEN-1:0]     w_alu;

    assign iss_ready = ~&r_busy;
    assign rs_full   = &r_busy;
    assign res_req   = r_res_req;
    assign res_tag   = r_res_tag;
    assign res_val   = r_res_val;

    // Scan downward so the last hit is the lowest index.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        w_has_rdy  = 1'b0;
        w_sel_idx  = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_busy[i] && r_s1_rdy[i] && r_s2_rdy[i]) begin
                w_has_rdy = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    assign w_do_issue = iss_valid && w_has_free;
    assign w_dispatch = w_has_rdy && (!r_res_req || res_grant);

    always_comb begin
        w_s1_rdy_in = iss_s1_rdy;
        w_s1_val_in = iss_s1_val;
        w_s2_rdy_in = iss_s2_rdy;
        w_s2_val_in = iss_s2_val;
`ifdef RTYPE_CDB_BYPASS_EN
        if (!iss_s1_rdy && cdb_valid && (cdb_tag == iss_s1_tag)) begin
            w_s1_rdy_in = 1'b1;
            w_s1_val_in = cdb_val;
        end
        if (!iss_s2_rdy && cdb_valid && (cdb_tag == iss_s2_tag)) begin
            w_s2_rdy_in = 1'b1;
            w_s2_val_in = cdb_val;
        end
`endif
    end

    assign w_a  = r_s1_val[w_sel_idx];
    assign w_b  = r_s2_val[w_sel_idx];
    assign w_sh = w_b[4:0];

    always_comb begin
        w_alu = '0;
        case (r_funct[w_sel_idx])
            F_ADD:  w_alu = w_a + w_b;
            F_SUB:  w_alu = w_a - w_b;
            F_SLL:  w_alu = w_a << w_sh;
            F_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            F_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            F_XOR:  w_alu = w_a ^ w_b;
            F_SRL:  w_alu = w_a >> w_sh;
            F_SRA:  w_alu = $unsigned($signed(w_a) >>> w_sh);
            F_OR:   w_alu = w_a | w_b;
            F_AND:  w_alu = w_a & w_b;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy   <= '0;
            r_s1_rdy <= '0;
            r_s2_rdy <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_funct[i]  <= '0;
                r_dtag[i]   <= '0;
                r_s1_tag[i] <= '0;
                r_s1_val[i] <= '0;
                r_s2_tag[i] <= '0;
                r_s2_val[i] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_busy[i] && cdb_valid) begin
                    if (!r_s1_rdy[i] && (r_s1_tag[i] == cdb_tag)) begin
                        r_s1_rdy[i] <= 1'b1;
                        r_s1_val[i] <= cdb_val;
                    end
                    if (!r_s2_rdy[i] && (r_s2_tag[i] == cdb_tag)) begin
                        r_s2_rdy[i] <= 1'b1;
                        r_s2_val[i] <= cdb_val;
                    end
                end
                if (w_dispatch && (w_sel_idx == IDX_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
                // Issue only targets a free entry, never the dispatching one.
                if (w_do_issue && (w_free_idx == IDX_W'(i))) begin
                    r_busy[i]   <= 1'b1;
                    r_funct[i]  <= iss_funct;
                    r_dtag[i]   <= iss_dest_tag;
                    r_s1_rdy[i] <= w_s1_rdy_in;
                    r_s1_tag[i] <= iss_s1_tag;
                    r_s1_val[i] <= w_s1_val_in;
                    r_s2_rdy[i] <= w_s2_rdy_in;
                    r_s2_tag[i] <= iss_s2_tag;
                    r_s2_val[i] <= w_s2_val_in;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_res_req <= 1'b0;
            r_res_tag <= '0;
            r_res_val <= '0;
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_res_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dispatch) begin
                        r_state   <= S_PEND;
                        r_res_req <= 1'b1;
                        r_res_tag <= r_dtag[w_sel_idx];
                        r_res_val <= w_alu;
                    end
                end
                S_PEND: begin
                    if (res_grant) begin
                        if (w_dispatch) begin
                            r_res_tag <= r_dtag[w_sel_idx];
                            r_res_val <= w_alu;
                        end else begin
                            r_state   <= S_IDLE;
                            r_res_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_res_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
